pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Program-counter/fetch sequencer that sits directly upstream of the halt detector.
- Produces the current PC (drives the detector's PC_Curr) and consumes its combinational halt.
- Advances the PC sequentially, or redirects it on branch or jump, honouring stalls from the datapath.
- Runs a start/run/halt lifecycle, with a one-cycle done pulse and an instruction-retire counter for the testbench.

Parameters:
- PC_W, 8, width of the program counter.
- START_ADDR, 8'h00, PC value loaded at reset and on every start.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  one-cycle pulse that begins program execution.
- halt  input  1  combinational halt from the halt detector; 1 means the current pc equals the end PC.
- stall  input  1  datapath stall; hold the PC this cycle.
- branch_taken  input  1  take a PC-relative branch this cycle.
- branch_offset  input  PC_W  signed two's-complement offset, added to pc.
- jump  input  1  take an absolute jump this cycle.
- jump_target  input  PC_W  absolute jump destination.
- pc  output  PC_W  current program counter.
- pc_valid  output  1  pc holds a live fetch address (state RUN).
- busy  output  1  state is RUN.
- done  output  1  one-cycle pulse on entry to HALTED.
- retired  output  CNT_W  count of instructions retired since the last start.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, pc=START_ADDR, pc_valid=0, busy=0, done=0, retired=0.
- Reset release is synchronous to clk. Reset asserted mid-RUN aborts immediately; no done pulse is issued.
- States: IDLE, RUN, HALTED. All outputs are registered; pc_valid and busy equal (state==RUN).
- IDLE:
  - start=1 -> RUN next cycle; pc=START_ADDR, retired=0.
  - All other inputs are ignored.
- RUN: the next-PC priority per clock edge, highest first, is:
  1. halt=1 -> HALTED; pc holds; done=1 for exactly the next cycle; retired unchanged.
  2. stall=1 -> pc holds; retired unchanged.
  3. jump=1 -> pc=jump_target; retired+1.
  4. branch_taken=1 -> pc=pc+sign_ext(branch_offset); retired+1.
  5. Otherwise -> pc=pc+1; retired+1.
- RUN, further rules:
  - start is ignored.
  - halt beats stall, jump and branch in the same cycle.
  - jump beats branch.
- HALTED:
  - pc holds its final value, so the halt detector keeps halt asserted.
  - start=1 -> RUN; pc=START_ADDR, retired=0.
  - done is a single-cycle pulse, then 0.
- Arithmetic:
  - PC arithmetic is modulo 2^PC_W: pc=8'hFF +1 wraps to 8'h00; 8'h02 + (-4) gives 8'hFE.
  - retired saturates at all-ones; it does not wrap.
- halt is sampled only in RUN. halt=1 seen in IDLE or HALTED has no effect.
- No combinational path from any input to any output.

Decomposition:
- Shared package (cpu_pkg):
  - typedef enum logic [1:0] {IDLE, RUN, HALTED} seq_state_t.
  - localparam PC_W_DEFAULT=8.
  - typedef logic [PC_W-1:0] pc_t.
- One natural sub-module: pc_next_calc, purely combinational. It takes pc, stall, jump, jump_target, branch_taken and branch_offset, and returns next_pc plus an advance flag. The FSM and counters stay in pc_sequencer.

Test Plan:
- Reset then start: reset=0 for 2 cycles, release, start pulse -> pc_valid=1 next cycle with pc=8'h00; pc=8'h01 and 8'h02 on the following cycles; retired=2.
- Halt hit: run to pc=8'h05, drive halt=1 -> next cycle busy=0, pc stays 8'h05, done=1 for exactly one cycle; retired=5; pc is unchanged 10 cycles later.
- Branch, jump and priority:
  - At pc=8'h10, branch_taken with offset 8'hFC -> pc=8'h0C.
  - At pc=8'h0C, jump=1 with target 8'h40 and branch_taken=1 together -> pc=8'h40.
  - stall=1 together with jump -> pc held.
- Wrap-around: jump to 8'hFF, then one free step -> pc=8'h00, retired increments.
- Simultaneous halt, stall and jump in one cycle -> HALTED, pc unchanged, done pulse.
- Restart and abort:
  - start in HALTED -> pc=8'h00, retired=0, busy=1.
  - Async reset asserted mid-RUN (between clk edges) -> outputs clear immediately with no done pulse.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the fetch front end: sequencer state encoding and PC type.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } seq_state_t;

  localparam int PC_W_DEFAULT = 8;

  typedef logic [PC_W_DEFAULT-1:0] pc_t;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection for a running sequencer.
// Priority: stall > jump > branch > sequential.
module pc_next_calc #(
  parameter int PC_W = 8
) (
  input  logic [PC_W-1:0] pc,
  input  logic            stall,
  input  logic            jump,
  input  logic [PC_W-1:0] jump_target,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_offset,
  output logic [PC_W-1:0] next_pc,
  output logic            advance
);

  always_comb begin
    next_pc = pc;
    advance = 1'b0;
    if (stall) begin
      next_pc = pc;
      advance = 1'b0;
    end else if (jump) begin
      next_pc = jump_target;
      advance = 1'b1;
    end else if (branch_taken) begin
      // Same-width add of a two's-complement offset wraps modulo 2^PC_W.
      next_pc = pc + branch_offset;
      advance = 1'b1;
    end else begin
      next_pc = pc + 1'b1;
      advance = 1'b1;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with IDLE/RUN/HALTED lifecycle, done pulse and
// saturating retired-instruction counter. All outputs come straight from flops.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int              PC_W       = 8,
  parameter logic [PC_W-1:0] START_ADDR = '0,
  parameter int              CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [PC_W-1:0]  branch_offset,
  input  logic             jump,
  input  logic [PC_W-1:0]  jump_target,
  output logic [PC_W-1:0]  pc,
  output logic             pc_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] retired
);

  seq_state_t       state_q;
  logic [PC_W-1:0]  pc_q;
  logic             run_q;
  logic             done_q;
  logic [CNT_W-1:0] retired_q;
  logic [CNT_W-1:0] retired_d;
  logic [PC_W-1:0]  next_pc;
  logic             advance;

  pc_next_calc #(
    .PC_W(PC_W)
  ) u_next (
    .pc           (pc_q),
    .stall        (stall),
    .jump         (jump),
    .jump_target  (jump_target),
    .branch_taken (branch_taken),
    .branch_offset(branch_offset),
    .next_pc      (next_pc),
    .advance      (advance)
  );

  // Counter sticks at all-ones instead of wrapping.
  assign retired_d = (advance && (retired_q != {CNT_W{1'b1}})) ? retired_q + 1'b1 : retired_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pc_q      <= START_ADDR;
      run_q     <= 1'b0;
      done_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, HALTED: begin
          if (start) begin
            state_q   <= RUN;
            run_q     <= 1'b1;
            pc_q      <= START_ADDR;
            retired_q <= '0;
          end
        end
        RUN: begin
          if (halt) begin
            state_q <= HALTED;
            run_q   <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            pc_q      <= next_pc;
            retired_q <= retired_d;
          end
        end
        default: begin
          state_q <= IDLE;
          run_q   <= 1'b0;
        end
      endcase
    end
  end

  assign pc       = pc_q;
  assign pc_valid = run_q;
  assign busy     = run_q;
  assign done     = done_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: table of vectors through a scoreboard queue,
// plus hand sequences for halt hold, async abort and counter saturation.
module tb_pc_sequencer;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, halt, stall, branch_taken, jump;
  logic [7:0]  branch_offset, jump_target;
  logic [7:0]  pc;
  logic        pc_valid, busy, done;
  logic [15:0] retired;

  int total  = 0;
  int passed = 0;

  pc_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .halt         (halt),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_offset(branch_offset),
    .jump         (jump),
    .jump_target  (jump_target),
    .pc           (pc),
    .pc_valid     (pc_valid),
    .busy         (busy),
    .done         (done),
    .retired      (retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start, halt, stall, jump, br;
    logic [7:0]  jt, off;
    logic [7:0]  e_pc;
    logic        e_run, e_done;
    logic [15:0] e_ret;
  } vec_t;

  typedef struct {
    logic [7:0]  pc;
    logic        run, done;
    logic [15:0] ret;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) $display("FAIL %s actual=%0h required=%0h", name, act, req);
    else passed++;
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".pc"}, 32'(pc), 32'(e.pc));
    chk({tag, ".pc_valid"}, 32'(pc_valid), 32'(e.run));
    chk({tag, ".busy"}, 32'(busy), 32'(e.run));
    chk({tag, ".done"}, 32'(done), 32'(e.done));
    chk({tag, ".retired"}, 32'(retired), 32'(e.ret));
  endtask

  function automatic vec_t mk(logic s, logic h, logic st, logic j, logic [7:0] jt,
                              logic b, logic [7:0] off, logic [7:0] epc,
                              logic erun, logic edone, logic [15:0] eret);
    vec_t v;
    v.start = s; v.halt = h; v.stall = st; v.jump = j; v.jt = jt; v.br = b; v.off = off;
    v.e_pc = epc; v.e_run = erun; v.e_done = edone; v.e_ret = eret;
    return v;
  endfunction

  // Drive one cycle of inputs, queue the expected post-edge outputs, then compare.
  task automatic step(input vec_t v, input string tag);
    exp_t e;
    start = v.start; halt = v.halt; stall = v.stall; jump = v.jump;
    jump_target = v.jt; branch_taken = v.br; branch_offset = v.off;
    e.pc = v.e_pc; e.run = v.e_run; e.done = v.e_done; e.ret = v.e_ret;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk_all(tag, e);
    $display("%s: pc=%02h valid=%0b done=%0b retired=%0d", tag, pc, pc_valid, done, retired);
  endtask

  task automatic idle_inputs();
    start = 0; halt = 0; stall = 0; jump = 0; branch_taken = 0;
    jump_target = 8'h00; branch_offset = 8'h00;
  endtask

  initial begin
    exp_t e;
    vec_t v;
    //          st h  sl j  jt     br off    pc    run dn ret
    vecs.push_back(mk(0, 1, 0, 1, 8'h55, 0, 8'h00, 8'h00, 0, 0, 16'd0)); // halt/jump in IDLE ignored
    vecs.push_back(mk(1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 1, 0, 16'd0)); // start
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h01, 1, 0, 16'd1));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h02, 1, 0, 16'd2));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h03, 1, 0, 16'd3));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h04, 1, 0, 16'd4));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h05, 1, 0, 16'd5));
    vecs.push_back(mk(0, 1, 0, 0, 8'h00, 0, 8'h00, 8'h05, 0, 1, 16'd5)); // halt hit
    vecs.push_back(mk(0, 1, 0, 0, 8'h00, 0, 8'h00, 8'h05, 0, 0, 16'd5)); // done drops

    idle_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    e.pc = 8'h00; e.run = 0; e.done = 0; e.ret = 16'd0;
    chk_all("reset", e);
    #2 reset = 1'b1;

    foreach (vecs[i]) step(vecs[i], $sformatf("vec%0d", i));

    // Halted with halt still asserted by the detector: nothing moves.
    v = mk(0, 1, 1, 1, 8'h77, 1, 8'h03, 8'h05, 0, 0, 16'd5);
    for (int i = 0; i < 10; i++) step(v, $sformatf("hold%0d", i));

    vecs.delete();
    vecs.push_back(mk(1, 1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 1, 0, 16'd0)); // restart from HALTED
    vecs.push_back(mk(0, 0, 0, 1, 8'h10, 0, 8'h00, 8'h10, 1, 0, 16'd1));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 1, 8'hFC, 8'h0C, 1, 0, 16'd2)); // 10 + (-4)
    vecs.push_back(mk(0, 0, 0, 1, 8'h40, 1, 8'h05, 8'h40, 1, 0, 16'd3)); // jump beats branch
    vecs.push_back(mk(0, 0, 1, 1, 8'h80, 0, 8'h00, 8'h40, 1, 0, 16'd3)); // stall beats jump
    vecs.push_back(mk(0, 0, 1, 0, 8'h00, 1, 8'h02, 8'h40, 1, 0, 16'd3)); // stall beats branch
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 1, 8'h02, 8'h42, 1, 0, 16'd4));
    vecs.push_back(mk(0, 0, 0, 1, 8'hFF, 0, 8'h00, 8'hFF, 1, 0, 16'd5));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 1, 0, 16'd6)); // wrap
    vecs.push_back(mk(0, 0, 0, 1, 8'h02, 0, 8'h00, 8'h02, 1, 0, 16'd7));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 1, 8'hFC, 8'hFE, 1, 0, 16'd8)); // 02 + (-4)
    vecs.push_back(mk(0, 1, 1, 1, 8'h30, 1, 8'h01, 8'hFE, 0, 1, 16'd8)); // halt beats all
    vecs.push_back(mk(0, 1, 0, 0, 8'h00, 0, 8'h00, 8'hFE, 0, 0, 16'd8));
    vecs.push_back(mk(1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 1, 0, 16'd0));
    vecs.push_back(mk(1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h01, 1, 0, 16'd1)); // start ignored in RUN
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h02, 1, 0, 16'd2));
    foreach (vecs[i]) step(vecs[i], $sformatf("vec2_%0d", i));

    // Asynchronous abort between edges: outputs clear before the next edge.
    idle_inputs();
    #2 reset = 1'b0;
    #1;
    e.pc = 8'h00; e.run = 0; e.done = 0; e.ret = 16'd0;
    chk_all("abort", e);
    @(posedge clk);
    #1;
    chk_all("abort_hold", e);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    chk_all("idle_after_abort", e);

    // Saturation: 65535 free steps reach all-ones, one more must not wrap.
    step(mk(1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 1, 0, 16'd0), "sat_start");
    idle_inputs();
    repeat (65534) @(posedge clk);
    step(mk(0, 0, 0, 0, 8'h00, 0, 8'h00, 8'hFF, 1, 0, 16'hFFFF), "sat_full");
    step(mk(0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 1, 0, 16'hFFFF), "sat_hold");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
